// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer pipeline stage with registered in_ready, flush,
// and a saturating backpressure (stall) counter.
module pipe_stage_buffer #(
  parameter int unsigned      WIDTH        = 96,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'('h13),
  parameter int unsigned      CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             clear_stats,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] stall_q;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign out_valid = (state == ONE) || (state == TWO);
  assign out_data  = out_valid ? main_q : BUBBLE_VALUE;
  assign in_ready  = in_ready_q;
  assign occupancy = 2'(state);
  assign stall_cnt = stall_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          next_state   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          next_state = TWO;
        end else if (out_fire) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low in TWO, so only the drain path exists here
        if (out_fire) begin
          load_main_skid = 1'b1;
          next_state     = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
    // Flush overrides the handshake outcome; payload loads are then don't-care
    if (flush) begin
      next_state = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != TWO) && !flush;
      if (clear_stats) begin
        stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  // Payload registers carry no reset: they are only observed outside EMPTY
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed vector table plus a randomized valid/ready/flush run against a queue model.
module tb_pipe_stage_buffer;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 2;
  localparam logic [W-1:0] BUBBLE = 16'h0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          flush;
  logic          clear_stats;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.WIDTH(W), .BUBBLE_VALUE(BUBBLE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .clear_stats(clear_stats),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic          rst_n;
    logic          iv;
    logic [W-1:0]  id;
    logic          ordy;
    logic          fl;
    logic          clr;
    logic          e_ir;
    logic          e_ov;
    logic [W-1:0]  e_od;
    logic [1:0]    e_occ;
    logic [CW-1:0] e_sc;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic iv, input logic [W-1:0] id,
                     input logic ordy, input logic fl, input logic clr,
                     input logic e_ir, input logic e_ov, input logic [W-1:0] e_od,
                     input logic [1:0] e_occ, input logic [CW-1:0] e_sc);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.clr = clr;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_sc = e_sc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic fl, input logic clr);
    rst_n = r; in_valid = iv; in_data = id; out_ready = ordy; flush = fl; clear_stats = clr;
  endtask

  task automatic check_all(input string tag, input logic e_ir, input logic e_ov,
                           input logic [W-1:0] e_od, input logic [1:0] e_occ,
                           input logic [CW-1:0] e_sc);
    check({tag, " in_ready"},  32'(in_ready),  32'(e_ir));
    check({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    check({tag, " out_data"},  32'(out_data),  32'(e_od));
    check({tag, " occupancy"}, 32'(occupancy), 32'(e_occ));
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(e_sc));
  endtask

  // Reference model state for the random phase
  logic [W-1:0]  q[$];
  logic          m_ir;
  logic [CW-1:0] m_sc;

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    //   rst iv id      ordy fl clr | ir ov od      occ sc
    // reset ignores in_valid / flush
    add(0, 1, 16'h55, 0, 1, 0,   0, 0, BUBBLE, 0, 0);
    add(0, 1, 16'h55, 0, 1, 0,   0, 0, BUBBLE, 0, 0);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 0);
    // streaming 1,2,3
    add(1, 1, 16'h01, 1, 0, 0,   1, 1, 16'h01, 1, 0);
    add(1, 1, 16'h02, 1, 0, 0,   1, 1, 16'h02, 1, 0);
    add(1, 1, 16'h03, 1, 0, 0,   1, 1, 16'h03, 1, 0);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 0);
    // backpressure A,B
    add(1, 1, 16'h0A, 0, 0, 0,   1, 1, 16'h0A, 1, 0);
    add(1, 1, 16'h0B, 0, 0, 0,   0, 1, 16'h0A, 2, 1);
    add(1, 1, 16'hEE, 0, 0, 0,   0, 1, 16'h0A, 2, 2);
    add(1, 0, 16'h00, 1, 0, 0,   1, 1, 16'h0B, 1, 2);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 2);
    add(1, 0, 16'h00, 1, 0, 1,   1, 0, BUBBLE, 0, 0);
    // flush in TWO with 0xC offered
    add(1, 1, 16'h21, 0, 0, 0,   1, 1, 16'h21, 1, 0);
    add(1, 1, 16'h22, 0, 0, 0,   0, 1, 16'h21, 2, 1);
    add(1, 1, 16'h0C, 0, 1, 0,   0, 0, BUBBLE, 0, 2);
    add(1, 1, 16'h0C, 1, 0, 0,   1, 0, BUBBLE, 0, 2);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 2);
    // flush in EMPTY
    add(1, 0, 16'h00, 1, 1, 0,   0, 0, BUBBLE, 0, 2);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 2);
    // flush in ONE during in_fire & out_fire
    add(1, 1, 16'h31, 1, 0, 0,   1, 1, 16'h31, 1, 2);
    add(1, 1, 16'h32, 1, 1, 0,   0, 0, BUBBLE, 0, 2);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 2);
    // saturation: 1,2,3,3,3,3 then clear beats increment
    add(1, 1, 16'h41, 0, 0, 1,   1, 1, 16'h41, 1, 0);
    add(1, 0, 16'h00, 0, 0, 0,   1, 1, 16'h41, 1, 1);
    add(1, 0, 16'h00, 0, 0, 0,   1, 1, 16'h41, 1, 2);
    add(1, 0, 16'h00, 0, 0, 0,   1, 1, 16'h41, 1, 3);
    add(1, 0, 16'h00, 0, 0, 0,   1, 1, 16'h41, 1, 3);
    add(1, 0, 16'h00, 0, 0, 0,   1, 1, 16'h41, 1, 3);
    add(1, 0, 16'h00, 0, 0, 0,   1, 1, 16'h41, 1, 3);
    add(1, 0, 16'h00, 0, 0, 1,   1, 1, 16'h41, 1, 0);
    // reset while holding two entries
    add(1, 1, 16'h51, 0, 0, 0,   0, 1, 16'h41, 2, 1);
    add(0, 1, 16'h66, 1, 0, 0,   0, 0, BUBBLE, 0, 0);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 0);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 0);
    add(1, 1, 16'h77, 1, 0, 0,   1, 1, 16'h77, 1, 0);
    add(1, 0, 16'h00, 1, 0, 0,   1, 0, BUBBLE, 0, 0);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
      @(posedge clk); #1;
      check_all($sformatf("v%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od,
                vecs[i].e_occ, vecs[i].e_sc);
    end

    // Random valid/ready with periodic flush; starts from the idle state left above
    q.delete();
    m_ir = 1'b1;
    m_sc = '0;
    for (int unsigned cyc = 0; cyc < 400; cyc++) begin
      logic          iv, ordy, fl, clr, in_f, out_f, stall;
      logic [W-1:0]  d;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ((cyc % 37) == 36);
      clr  = ((cyc % 53) == 52);
      d    = W'(16'h1000 + cyc);
      drive(1'b1, iv, d, ordy, fl, clr);

      in_f  = iv & m_ir;
      out_f = (q.size() != 0) & ordy;
      stall = (q.size() != 0) & !ordy;
      if (out_f) void'(q.pop_front());
      if (in_f)  q.push_back(d);
      if (fl)    q.delete();
      m_ir = (q.size() != 2) && !fl;
      if (clr) m_sc = '0;
      else if (stall && (m_sc != '1)) m_sc = m_sc + CW'(1);

      @(posedge clk); #1;
      check_all($sformatf("r%0d", cyc), m_ir, (q.size() != 0),
                (q.size() != 0) ? q[0] : BUBBLE, 2'(q.size()), m_sc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 96, meaning payload width in bits (minimum 1).
REQ-002 SHALL have parameter BUBBLE_VALUE, default WIDTH'h13, meaning payload driven while out_valid=0 (NOP encoding).
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall counter width (minimum 2).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning upstream payload valid.
REQ-007 SHALL have port in_data, input, WIDTH, meaning upstream payload.
REQ-008 SHALL have port in_ready, output, 1, meaning the buffer accepts in_data this cycle; it is a registered output.
REQ-009 SHALL have port out_valid, output, 1, meaning the downstream payload is valid.
REQ-010 SHALL have port out_data, output, WIDTH, meaning the downstream payload.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream accepts.
REQ-012 SHALL have port flush, input, 1, meaning discard all held and incoming entries.
REQ-013 SHALL have port clear_stats, input, 1, meaning zero stall_cnt.
REQ-014 SHALL have port occupancy, output, 2, meaning the held entry count, 0..2.
REQ-015 SHALL have port stall_cnt, output, CNT_W, meaning the saturating count of backpressured cycles.

Function
REQ-016 SHALL hold two entries: a main register that drives out_data, and a skid register.
REQ-017 SHALL use states EMPTY (occupancy 0), ONE (occupancy 1) and TWO (occupancy 2).
REQ-018 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-019 SHALL drive out_valid=1 exactly when the state is ONE or TWO.
REQ-020 SHALL drive out_data = main when out_valid=1, and BUBBLE_VALUE otherwise.
REQ-021 SHALL make transitions from EMPTY as follows: in_fire loads main and moves to ONE; otherwise it stays in EMPTY.
REQ-022 SHALL make transitions from ONE as follows:
- in_fire & out_fire: load main from in_data, stay ONE.
- in_fire & !out_fire: load skid from in_data, go to TWO.
- !in_fire & out_fire: go to EMPTY.
- neither: hold.
REQ-023 SHALL make transitions from TWO as follows: out_fire copies skid into main and moves to ONE; otherwise it holds (no in_fire is possible).
REQ-024 SHALL register in_ready so that in_ready(next) = (next_state != TWO) & !flush.
REQ-025 SHALL give a latency of 1 cycle: in_fire at cycle N in EMPTY makes out_valid=1 with that data at cycle N+1.
REQ-026 SHALL sustain throughput of 1 entry/cycle while out_ready=1.
REQ-027 SHALL preserve FIFO order; no entry is duplicated or lost except by flush.
REQ-028 SHALL treat flush=1 with priority over all handshakes:
- next state is EMPTY.
- any in_fire that cycle is discarded.
- out_fire that cycle still counts as a transfer downstream.
- in_ready is 0 the following cycle and returns to 1 the cycle after.
REQ-029 SHALL make flush in EMPTY a no-op, apart from deasserting in_ready for one cycle.
REQ-030 SHALL increment stall_cnt by 1 on each cycle where out_valid & !out_ready.
REQ-031 SHALL saturate stall_cnt at 2^CNT_W-1 with no wrap.
REQ-032 SHALL give clear_stats priority over increment: stall_cnt becomes 0 the next cycle.
REQ-033 SHALL leave stall_cnt unaffected by flush.
REQ-034 SHALL ignore payload registers when the state is EMPTY; they need not be reset.

Reset
REQ-035 SHALL, while rst_n=0 at a clock edge, set: state EMPTY, in_ready=0, out_valid=0, out_data=BUBBLE_VALUE, occupancy=0, stall_cnt=0.
REQ-036 SHALL set in_ready=1 on the first edge with rst_n=1.
REQ-037 SHALL drop held entries on reset mid-operation, with no partial transfer.
REQ-038 SHALL ignore in_valid, flush and clear_stats while rst_n=0.

Verification
REQ-039 SHALL cover streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the next three cycles, occupancy never exceeds 1.
REQ-040 SHALL cover backpressure: push 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB emitted in order; stall_cnt equals the stalled cycle count.
REQ-041 SHALL cover flush in TWO: occupancy=2, flush=1 with in_valid=1 (0xC) -> next cycle out_valid=0, out_data=0x13, occupancy=0, in_ready=0; the cycle after, in_ready=1; 0xC never appears.
REQ-042 SHALL cover saturation: CNT_W=2, hold out_valid=1 & out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3; clear_stats -> 0.
REQ-043 SHALL cover reset mid-operation: occupancy=2, rst_n=0 one cycle -> all outputs at REQ-035 values; after release, in_ready=1 one cycle later and the old entries never appear.
REQ-044 SHALL cover random valid/ready with periodic flush against a reference queue model -> ordering per REQ-027 and REQ-028, and no lost or duplicated entries.
